// File: rtl/clock_monitor_pkg.sv
// Shared types and elaboration-time helpers for the slow-clock monitor.
package clock_monitor_pkg;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        LOCKED  = 2'd1,
        LOST    = 2'd2
    } mon_state_t;

    function automatic int unsigned nominal_cycles(input int unsigned ref_hz, input int unsigned exp_hz);
        return ref_hz / exp_hz;
    endfunction

    function automatic int unsigned tol_cycles(input int unsigned nom, input int unsigned pct);
        return (nom * pct) / 100;
    endfunction

endpackage

// File: rtl/edge_synchronizer.sv
// Brings an asynchronous slow signal into the clk domain and emits one-cycle edge strobes.
module edge_synchronizer (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise,
    output logic fall,
    output logic rise_c
);

    logic sync1;
    logic sync2;
    logic dly;
    logic fall_c;

    // Early edge indications, one cycle ahead of the registered strobes.
    assign rise_c = sync2 & ~dly;
    assign fall_c = ~sync2 & dly;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            dly   <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= sig;
            sync2 <= sync1;
            dly   <= sync2;
            rise  <= rise_c;
            fall  <= fall_c;
        end
    end

endmodule

// File: rtl/clock_monitor.sv
// Measures the period of a slow external clock in reference cycles and tracks lock / loss.
module clock_monitor
    import clock_monitor_pkg::*;
#(
    parameter int unsigned REF_FREQUENCY      = 50000000,
    parameter int unsigned EXPECTED_FREQUENCY = 1000,
    parameter int unsigned TOLERANCE_PCT      = 5,
    parameter int unsigned LOCK_COUNT         = 4,
    localparam int unsigned NOMINAL = nominal_cycles(REF_FREQUENCY, EXPECTED_FREQUENCY),
    localparam int unsigned TOL     = tol_cycles(NOMINAL, TOLERANCE_PCT),
    localparam int unsigned TIMEOUT = 2 * NOMINAL,
    localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             in_range,
    output logic             locked,
    output logic             lost
);

    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] WIN_LO    = CNT_W'(NOMINAL - TOL);
    localparam logic [CNT_W-1:0] WIN_HI    = CNT_W'(NOMINAL + TOL);

    logic              rise_c;
    logic [CNT_W-1:0]  cnt;
    logic              armed;
    logic [GOOD_W-1:0] good_cnt;
    mon_state_t        state;
    logic              in_window_c;
    logic              timeout_c;

    edge_synchronizer u_sync (
        .clk    (clk),
        .reset  (reset),
        .sig    (clk_in),
        .rise   (rise_pulse),
        .fall   (fall_pulse),
        .rise_c (rise_c)
    );

    // The counter's value at a rise is the distance between consecutive rise strobes.
    assign in_window_c = (cnt >= WIN_LO) && (cnt <= WIN_HI);
    assign timeout_c   = (cnt == TIMEOUT_V) && !rise_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (rise_c) begin
            cnt <= CNT_W'(1);
        end else if (cnt != TIMEOUT_V) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Lock state machine; locked trails the state by one cycle except on timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ACQUIRE;
            armed        <= 1'b0;
            good_cnt     <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            in_range     <= 1'b0;
            locked       <= 1'b0;
            lost         <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            locked       <= (state == LOCKED) && !timeout_c;
            case (state)
                ACQUIRE, LOCKED: begin
                    if (rise_c) begin
                        if (armed) begin
                            period       <= cnt;
                            period_valid <= 1'b1;
                            in_range     <= in_window_c;
                            if (!in_window_c) begin
                                state    <= ACQUIRE;
                                good_cnt <= '0;
                            end else if (state == ACQUIRE) begin
                                if (good_cnt == GOOD_W'(LOCK_COUNT - 1)) begin
                                    state    <= LOCKED;
                                    good_cnt <= GOOD_W'(LOCK_COUNT);
                                end else begin
                                    good_cnt <= good_cnt + GOOD_W'(1);
                                end
                            end
                        end else begin
                            armed <= 1'b1;
                        end
                    end else if (timeout_c) begin
                        state    <= LOST;
                        lost     <= 1'b1;
                        armed    <= 1'b0;
                        good_cnt <= '0;
                        in_range <= 1'b0;
                    end
                end
                LOST: begin
                    if (rise_c) begin
                        state <= ACQUIRE;
                        lost  <= 1'b0;
                        armed <= 1'b1;
                    end
                end
                default: begin
                    state <= ACQUIRE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor with NOMINAL=100, window 95..105, TIMEOUT=200.
module tb_clock_monitor;
    import clock_monitor_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk_in;
    logic       rise_pulse;
    logic       fall_pulse;
    logic [7:0] period;
    logic       period_valid;
    logic       in_range;
    logic       locked;
    logic       lost;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int rise_cnt = 0, pv_cnt = 0, lost_cnt = 0, unlock_cnt = 0;
    int rise_cyc = -1, pv_cyc = -1, lock_cyc = -1, unlock_cyc = -1, lost_cyc = -1;
    logic [7:0] last_period = 8'd0;
    logic       last_in = 1'b0;
    logic       prev_locked = 1'b0;
    logic       prev_lost = 1'b0;

    clock_monitor #(
        .REF_FREQUENCY      (1000),
        .EXPECTED_FREQUENCY (10),
        .TOLERANCE_PCT      (5),
        .LOCK_COUNT         (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clk_in       (clk_in),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .period       (period),
        .period_valid (period_valid),
        .in_range     (in_range),
        .locked       (locked),
        .lost         (lost)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Advance one cycle and record events seen on the outputs at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (rise_pulse) begin rise_cnt++; rise_cyc = cyc; end
        if (period_valid) begin pv_cnt++; pv_cyc = cyc; last_period = period; last_in = in_range; end
        if (locked && !prev_locked) lock_cyc = cyc;
        if (!locked && prev_locked) begin unlock_cyc = cyc; unlock_cnt++; end
        if (lost && !prev_lost) begin lost_cyc = cyc; lost_cnt++; end
        prev_locked = locked;
        prev_lost   = lost;
    endtask

    task automatic send_period(input int p);
        clk_in = 1'b1;
        repeat (p / 2) tick();
        clk_in = 1'b0;
        repeat (p - p / 2) tick();
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        clk_in = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();
        total++;
        if ({rise_pulse, fall_pulse, period_valid, in_range, locked, lost} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000000",
                     {rise_pulse, fall_pulse, period_valid, in_range, locked, lost});
        end
        total++;
        if (period !== 8'd0) begin bad++; $display("FAIL reset_period: got %0d want 0", period); end
        total++;
        if (dut.state !== ACQUIRE) begin bad++; $display("FAIL reset_state: got %0d want %0d", dut.state, ACQUIRE); end
        total++;
        if (rise_cnt !== 0) begin bad++; $display("FAIL reset_no_rise: got %0d want 0", rise_cnt); end
    endtask

    task automatic test_square_wave();
        int p0;
        clk_in = 1'b1;
        tick(); tick();
        total++;
        if (rise_pulse !== 1'b0) begin bad++; $display("FAIL rise_early: got %b want 0", rise_pulse); end
        tick();
        total++;
        if (rise_pulse !== 1'b1) begin bad++; $display("FAIL rise_latency: got %b want 1", rise_pulse); end
        total++;
        if (period_valid !== 1'b0) begin bad++; $display("FAIL first_rise_pv: got %b want 0", period_valid); end
        repeat (47) tick();
        clk_in = 1'b0;
        tick(); tick();
        total++;
        if (fall_pulse !== 1'b0) begin bad++; $display("FAIL fall_early: got %b want 0", fall_pulse); end
        tick();
        total++;
        if (fall_pulse !== 1'b1) begin bad++; $display("FAIL fall_latency: got %b want 1", fall_pulse); end
        repeat (47) tick();
        p0 = pv_cnt;
        for (int i = 1; i <= 4; i++) begin
            send_period(100);
            total++;
            if (last_period !== 8'd100 || last_in !== 1'b1 || pv_cnt !== p0 + i) begin
                bad++;
                $display("FAIL sq_period_%0d: got period=%0d in_range=%b pv=%0d want 100 1 %0d",
                         i, last_period, last_in, pv_cnt - p0, i);
            end
            if (i < 4) begin
                total++;
                if (locked !== 1'b0) begin bad++; $display("FAIL sq_early_lock_%0d: got %b want 0", i, locked); end
            end
        end
        total++;
        if (locked !== 1'b1 || lock_cyc !== pv_cyc + 1) begin
            bad++;
            $display("FAIL sq_lock: got locked=%b at %0d want 1 at %0d", locked, lock_cyc, pv_cyc + 1);
        end
    endtask

    task automatic test_unlock_relock();
        send_period(110);
        send_period(100);
        total++;
        if (last_period !== 8'd110 || last_in !== 1'b0) begin
            bad++;
            $display("FAIL long_period: got period=%0d in_range=%b want 110 0", last_period, last_in);
        end
        total++;
        if (locked !== 1'b0 || unlock_cyc !== pv_cyc + 1) begin
            bad++;
            $display("FAIL unlock_timing: got locked=%b drop at %0d want 0 at %0d", locked, unlock_cyc, pv_cyc + 1);
        end
        for (int i = 1; i <= 4; i++) begin
            send_period(100);
            if (i == 3) begin
                total++;
                if (locked !== 1'b0) begin bad++; $display("FAIL relock_early: got %b want 0", locked); end
            end
        end
        total++;
        if (locked !== 1'b1 || last_period !== 8'd100) begin
            bad++;
            $display("FAIL relock: got locked=%b period=%0d want 1 100", locked, last_period);
        end
    endtask

    task automatic test_window_edges();
        int u0;
        u0 = unlock_cnt;
        send_period(96);
        send_period(104);
        send_period(96);
        send_period(104);
        send_period(94);
        total++;
        if (locked !== 1'b1 || unlock_cnt !== u0 || last_period !== 8'd104 || last_in !== 1'b1) begin
            bad++;
            $display("FAIL window_hold: got locked=%b unlocks=%0d period=%0d in_range=%b want 1 0 104 1",
                     locked, unlock_cnt - u0, last_period, last_in);
        end
        send_period(100);
        total++;
        if (last_period !== 8'd94 || last_in !== 1'b0 || locked !== 1'b0 || unlock_cnt !== u0 + 1) begin
            bad++;
            $display("FAIL window_short: got period=%0d in_range=%b locked=%b unlocks=%0d want 94 0 0 1",
                     last_period, last_in, locked, unlock_cnt - u0);
        end
    endtask

    task automatic test_lost_restart();
        int l0, r, p0;
        repeat (4) send_period(100);
        total++;
        if (locked !== 1'b1) begin bad++; $display("FAIL prelost_lock: got %b want 1", locked); end
        l0 = lost_cnt;
        r  = rise_cyc;
        for (int i = 0; i < 300 && lost_cnt == l0; i++) tick();
        total++;
        if (lost_cnt !== l0 + 1 || lost_cyc - r !== 200) begin
            bad++;
            $display("FAIL lost_timing: got lost events=%0d delay=%0d want 1 200", lost_cnt - l0, lost_cyc - r);
        end
        total++;
        if (lost !== 1'b1 || locked !== 1'b0 || in_range !== 1'b0) begin
            bad++;
            $display("FAIL lost_flags: got lost=%b locked=%b in_range=%b want 1 0 0", lost, locked, in_range);
        end
        repeat (20) tick();
        p0 = pv_cnt;
        send_period(100);
        total++;
        if (pv_cnt !== p0 || lost !== 1'b0 || dut.state !== ACQUIRE) begin
            bad++;
            $display("FAIL restart_first: got pv=%0d lost=%b state=%0d want 0 0 %0d",
                     pv_cnt - p0, lost, dut.state, ACQUIRE);
        end
        send_period(100);
        total++;
        if (pv_cnt !== p0 + 1 || last_period !== 8'd100 || last_in !== 1'b1) begin
            bad++;
            $display("FAIL restart_second: got pv=%0d period=%0d in_range=%b want 1 100 1",
                     pv_cnt - p0, last_period, last_in);
        end
    endtask

    task automatic test_reset_mid();
        int r0;
        repeat (3) send_period(100);
        total++;
        if (locked !== 1'b1) begin bad++; $display("FAIL premid_lock: got %b want 1", locked); end
        clk_in = 1'b1;
        repeat (20) tick();
        reset = 1'b1;
        tick();
        total++;
        if ({rise_pulse, fall_pulse, period_valid, in_range, locked, lost} !== 6'b0 || period !== 8'd0) begin
            bad++;
            $display("FAIL mid_reset: got flags=%b period=%0d want 000000 0",
                     {rise_pulse, fall_pulse, period_valid, in_range, locked, lost}, period);
        end
        repeat (2) tick();
        reset = 1'b0;
        r0 = rise_cnt;
        tick(); tick();
        total++;
        if (rise_pulse !== 1'b0) begin bad++; $display("FAIL release_early: got %b want 0", rise_pulse); end
        tick();
        total++;
        if (rise_pulse !== 1'b1) begin bad++; $display("FAIL release_rise: got %b want 1", rise_pulse); end
        repeat (10) tick();
        total++;
        if (rise_cnt !== r0 + 1) begin bad++; $display("FAIL release_single: got %0d rises want 1", rise_cnt - r0); end
    endtask

    task automatic test_rise_vs_timeout();
        int r, l0, p0;
        r  = rise_cyc;
        l0 = lost_cnt;
        p0 = pv_cnt;
        while (cyc < r + 97) tick();
        clk_in = 1'b0;
        while (cyc < r + 197) tick();
        clk_in = 1'b1;
        for (int i = 0; i < 10 && pv_cnt == p0; i++) tick();
        total++;
        if (pv_cnt !== p0 + 1 || pv_cyc !== r + 200 || last_period !== 8'd200 || last_in !== 1'b0) begin
            bad++;
            $display("FAIL edge_200: got pv=%0d at %0d period=%0d in_range=%b want 1 at %0d 200 0",
                     pv_cnt - p0, pv_cyc, last_period, last_in, r + 200);
        end
        total++;
        if (lost_cnt !== l0 || lost !== 1'b0 || dut.state !== ACQUIRE) begin
            bad++;
            $display("FAIL edge_no_lost: got lost events=%0d lost=%b state=%0d want 0 0 %0d",
                     lost_cnt - l0, lost, dut.state, ACQUIRE);
        end
    endtask

    initial begin
        reset  = 1'b1;
        clk_in = 1'b0;
        test_reset();
        test_square_wave();
        test_unlock_relock();
        test_window_edges();
        test_lost_restart();
        test_reset_mid();
        test_rise_vs_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_monitor.md
# clock_monitor

Receive-side companion to the team's clock divider. It takes a slow clock or tick signal, such as a divided clock returned from another block or pin, into the reference clock domain. It synchronizes the signal, produces single-cycle rise and fall strobes, and measures each period in reference cycles. It also tracks lock to the expected frequency and flags loss of clock, so downstream logic can use clean enables instead of a derived clock.

## Interface
Parameters:
- REF_FREQUENCY, 50000000: frequency of `clk` in Hz.
- EXPECTED_FREQUENCY, 1000: nominal frequency of `clk_in` in Hz.
- TOLERANCE_PCT, 5: allowed period deviation in percent (integer).
- LOCK_COUNT, 4: number of consecutive in-range periods required for lock.
- Derived, not overridable:
  - NOMINAL = REF_FREQUENCY/EXPECTED_FREQUENCY
  - TOL = NOMINAL*TOLERANCE_PCT/100 (floor)
  - TIMEOUT = 2*NOMINAL
  - CNT_W = $clog2(TIMEOUT+1)

Ports:
- clk, in, 1: reference clock. This is the only clock.
- reset, in, 1: synchronous, active-high reset.
- clk_in, in, 1: asynchronous slow clock to monitor.
- rise_pulse, out, 1: one-cycle strobe for each synchronized rising edge.
- fall_pulse, out, 1: one-cycle strobe for each synchronized falling edge.
- period, out, CNT_W: last measured period in `clk` cycles.
- period_valid, out, 1: one-cycle strobe when `period` updates.
- in_range, out, 1: the last measured period satisfies NOMINAL-TOL ≤ period ≤ NOMINAL+TOL.
- locked, out, 1: the state machine is in LOCKED.
- lost, out, 1: the state machine is in LOST.

## Operation
- Input capture: `clk_in` passes through a 2-FF synchronizer, then a delay register. Edge detection compares the synchronizer output with the delay register; the strobes are registered.
- Period counter:
  - Loads 1 in each cycle where `rise_pulse` is asserted; increments otherwise.
  - Saturates at TIMEOUT.
- Period capture: on a rise with measurement armed, `period` takes the counter value before the load. That value equals the cycle distance between consecutive `rise_pulse` strobes.
- FSM states: ACQUIRE (reset state), LOCKED, LOST. `good_cnt` is in range 0..LOCK_COUNT.
- ACQUIRE:
  - The first rise after entry only arms measurement. It produces no `period_valid`.
  - Each later rise pulses `period_valid`.
  - An in-range period increments `good_cnt`. When `good_cnt` reaches LOCK_COUNT, the FSM moves to LOCKED.
  - An out-of-range period clears `good_cnt`.
- LOCKED:
  - An out-of-range period moves to ACQUIRE with `good_cnt` = 0, measurement stays armed.
  - In-range periods hold LOCKED.
- Any state: the counter reaching TIMEOUT in a cycle with no rise moves to LOST. Measurement is disarmed and `good_cnt` clears.
- LOST: the next rise moves to ACQUIRE and arms measurement. No `period_valid` is produced for that rise.
- `fall_pulse` is informational only. It does not affect the FSM.
- Simultaneous events: if a rise and the TIMEOUT condition occur in the same cycle, the rise wins.
- Reset mid-operation: everything returns to reset values on the next `clk` edge. The synchronizer flops clear to 0, so a `clk_in` held high produces one `rise_pulse` after reset release.
- Reset values: rise_pulse=0, fall_pulse=0, period=0, period_valid=0, in_range=0, locked=0, lost=0. State is ACQUIRE and measurement is disarmed.

## Timing
- `rise_pulse`/`fall_pulse` go high exactly 3 `clk` cycles after the first edge that samples the new `clk_in` level. They last one cycle.
- `period_valid`, `period` and `in_range` update in the same cycle as the corresponding `rise_pulse`.
- `locked` asserts in the cycle after the LOCK_COUNT-th consecutive in-range `period_valid`.
- `lost` asserts in the cycle after the counter reaches TIMEOUT.
- `in_range` holds its value between `period_valid` strobes and clears on entry to LOST.
- Input constraint: `clk_in` high and low phases must each be ≥ 3 `clk` cycles; narrower pulses may be missed. EXPECTED_FREQUENCY ≤ REF_FREQUENCY/6.

## Structure
- Package `clock_monitor_pkg` contains:
  - State enum `mon_state_t` {ACQUIRE, LOCKED, LOST}.
  - Functions `nominal_cycles(ref, exp)` and `tol_cycles(nom, pct)`, used for elaboration-time localparams.
- Sub-module `edge_synchronizer`: 2-FF synchronizer, delay register and registered rise/fall strobes, with `clk`/`reset`. It is reused wherever an external slow signal enters the design.
- All other logic (counter, capture, FSM) lives in `clock_monitor`.

## Test plan
Unless noted, tests use REF_FREQUENCY=1000, EXPECTED_FREQUENCY=10, giving NOMINAL=100, TOL=5, window 95..105, TIMEOUT=200.
- Reset release with `clk_in` low: all outputs stay 0 and state is ACQUIRE.
- Square wave, period 100: exactly 3 cycles from input edge to strobe. The first rise gives no `period_valid`. `period`=100 with `in_range`=1 on every later rise; `locked`=1 after the 4th.
- Locked, then one 110-cycle period: `in_range`=0, `locked` drops the next cycle. It relocks after 4 more 100-cycle periods.
- Periods alternating 96/104: stays locked. Then one 94-cycle period: unlock.
- Stop `clk_in` while locked: `lost`=1 200 cycles after the last rise, `locked`=0. When the clock restarts, the first rise gives ACQUIRE with no `period_valid`, and the second gives `period`=100.
- Assert `reset` mid-period while locked: all outputs are 0 the next cycle. With `clk_in` high at release, a single `rise_pulse` appears 3 cycles later.
